// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - held ALU status flags, branch-condition evaluation and flag save stack
module alu_flag_unit #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flags_we,
  input  logic          co_in,
  input  logic          ovf_in,
  input  logic          z_in,
  input  logic          n_in,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  input  logic [3:0]    cond,
  output logic [3:0]    flags_q,
  output logic          cond_true,
  output logic [CW-1:0] count,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          stack_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [3:0]    mem [DEPTH];
  logic [3:0]    top_flags;
  logic [CW-1:0] count_m1;
  logic          push_only;
  logic          pop_only;
  logic          do_push;
  logic          do_pop;
  logic          new_err;

  // Individual flag views of the held register
  logic f_n, f_z, f_co, f_ovf;
  assign {f_n, f_z, f_co, f_ovf} = flags_q;

  assign stack_full  = (count == DEPTH_C);
  assign stack_empty = (count == '0);
  assign count_m1    = count - ONE_C;

  // Simultaneous push and pop cancel each other; only a lone request acts on the stack
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;
  assign do_push   = push_only & ~stack_full;
  assign do_pop    = pop_only & ~stack_empty;
  assign new_err   = (push_only & stack_full) | (pop_only & stack_empty);

  // Read the current top-of-stack entry without a narrowing index
  always_comb begin
    top_flags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_m1 == CW'(i)) top_flags = mem[i];
    end
  end

  // Branch condition decode on the held flags
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = f_z;
      4'd1:    cond_true = ~f_z;
      4'd2:    cond_true = f_co;
      4'd3:    cond_true = ~f_co;
      4'd4:    cond_true = f_n;
      4'd5:    cond_true = ~f_n;
      4'd6:    cond_true = f_ovf;
      4'd7:    cond_true = ~f_ovf;
      4'd8:    cond_true = f_co & ~f_z;
      4'd9:    cond_true = ~f_co | f_z;
      4'd10:   cond_true = (f_n == f_ovf);
      4'd11:   cond_true = (f_n != f_ovf);
      4'd12:   cond_true = ~f_z & (f_n == f_ovf);
      4'd13:   cond_true = f_z | (f_n != f_ovf);
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // Flag register: a fresh ALU result takes priority over a restore from the stack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= {n_in, z_in, co_in, ovf_in};
    end else if (do_pop) begin
      flags_q <= top_flags;
    end
  end

  // Occupancy counter doubles as the stack pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + ONE_C;
    end else if (do_pop) begin
      count <= count_m1;
    end
  end

  // Sticky misuse indicator; a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if (new_err) begin
      stack_err <= 1'b1;
    end else if (clr_err) begin
      stack_err <= 1'b0;
    end
  end

  // Snapshot storage captures the pre-edge flags; contents need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (count == CW'(i))) mem[i] <= flags_q;
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - directed self-checking bench for alu_flag_unit
module tb_alu_flag_unit;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          flags_we;
  logic          co_in, ovf_in, z_in, n_in;
  logic          push, pop, clr_err;
  logic [3:0]    cond;
  logic [3:0]    flags_q;
  logic          cond_true;
  logic [CW-1:0] count;
  logic          stack_full, stack_empty, stack_err;

  int passed = 0;
  int total  = 0;

  // Hand-built truth masks: bit f of entry c is the result of code c on flags f = {N,Z,CO,OVF}
  logic [15:0] mask [16];

  alu_flag_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flags_we    (flags_we),
    .co_in       (co_in),
    .ovf_in      (ovf_in),
    .z_in        (z_in),
    .n_in        (n_in),
    .push        (push),
    .pop         (pop),
    .clr_err     (clr_err),
    .cond        (cond),
    .flags_q     (flags_q),
    .cond_true   (cond_true),
    .count       (count),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] v);
    flags_we = 1'b1;
    {n_in, z_in, co_in, ovf_in} = v;
    step();
    flags_we = 1'b0;
  endtask

  task automatic do_push_op();
    push = 1'b1;
    step();
    push = 1'b0;
  endtask

  task automatic do_pop_op();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin
    mask[0]  = 16'hF0F0; mask[1]  = 16'h0F0F; mask[2]  = 16'hCCCC; mask[3]  = 16'h3333;
    mask[4]  = 16'hFF00; mask[5]  = 16'h00FF; mask[6]  = 16'hAAAA; mask[7]  = 16'h5555;
    mask[8]  = 16'h0C0C; mask[9]  = 16'hF3F3; mask[10] = 16'hAA55; mask[11] = 16'h55AA;
    mask[12] = 16'h0A05; mask[13] = 16'hF5FA; mask[14] = 16'hFFFF; mask[15] = 16'h0000;

    rst_n = 1'b0; flags_we = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    {n_in, z_in, co_in, ovf_in} = 4'b0000; cond = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 8'(flags_q), 8'h0);
    chk("rst_count", 8'(count), 8'h0);
    chk("rst_empty", 8'(stack_empty), 8'h1);
    chk("rst_full", 8'(stack_full), 8'h0);
    chk("rst_err", 8'(stack_err), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First load and a few condition codes
    load_flags(4'b1010);
    chk("load_1010", 8'(flags_q), 8'h0A);
    cond = 4'd2;  #1; chk("cs_1010", 8'(cond_true), 8'h1);
    cond = 4'd11; #1; chk("lt_1010", 8'(cond_true), 8'h1);
    cond = 4'd12; #1; chk("gt_1010", 8'(cond_true), 8'h0);

    // Full condition sweep
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        logic [15:0] m;
        m = mask[c];
        cond = 4'(c);
        #1;
        chk($sformatf("cond_c%0d_f%0d", c, f), 8'(cond_true), 8'(m[f]));
      end
    end

    // Save, overwrite, restore
    load_flags(4'b0100);
    do_push_op();
    chk("push1_count", 8'(count), 8'h1);
    load_flags(4'b0011);
    chk("overwrite", 8'(flags_q), 8'h03);
    do_pop_op();
    chk("restore", 8'(flags_q), 8'h04);
    chk("restore_count", 8'(count), 8'h0);
    chk("restore_empty", 8'(stack_empty), 8'h1);
    chk("restore_err", 8'(stack_err), 8'h0);

    // Overflow, LIFO order, underflow
    for (int i = 1; i <= 5; i++) begin
      load_flags(4'(i));
      do_push_op();
    end
    chk("ovf_count", 8'(count), 8'h4);
    chk("ovf_full", 8'(stack_full), 8'h1);
    chk("ovf_err", 8'(stack_err), 8'h1);
    chk("ovf_flags", 8'(flags_q), 8'h05);
    for (int k = 4; k >= 1; k--) begin
      do_pop_op();
      chk($sformatf("lifo_pop_%0d", k), 8'(flags_q), 8'(k));
      chk($sformatf("lifo_count_%0d", k), 8'(count), 8'(k - 1));
    end
    chk("drain_empty", 8'(stack_empty), 8'h1);
    do_pop_op();
    chk("unf_flags", 8'(flags_q), 8'h01);
    chk("unf_err", 8'(stack_err), 8'h1);
    chk("unf_count", 8'(count), 8'h0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_err", 8'(stack_err), 8'h0);
    pop = 1'b1; clr_err = 1'b1; step(); pop = 1'b0; clr_err = 1'b0;
    chk("err_beats_clr", 8'(stack_err), 8'h1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("clr_err2", 8'(stack_err), 8'h0);

    // Push together with a flag write saves the old flags
    load_flags(4'b0001);
    push = 1'b1; flags_we = 1'b1; {n_in, z_in, co_in, ovf_in} = 4'b1000;
    step();
    push = 1'b0; flags_we = 1'b0;
    chk("pushwe_flags", 8'(flags_q), 8'h08);
    chk("pushwe_count", 8'(count), 8'h1);
    do_pop_op();
    chk("pushwe_restore", 8'(flags_q), 8'h01);
    chk("pushwe_count0", 8'(count), 8'h0);

    // Push and pop together cancel
    do_push_op();
    push = 1'b1; pop = 1'b1; step(); push = 1'b0; pop = 1'b0;
    chk("pushpop_count", 8'(count), 8'h1);
    chk("pushpop_err", 8'(stack_err), 8'h0);
    chk("pushpop_flags", 8'(flags_q), 8'h01);

    // Pop together with a flag write: new flags win, stack still pops
    pop = 1'b1; flags_we = 1'b1; {n_in, z_in, co_in, ovf_in} = 4'b0110;
    step();
    pop = 1'b0; flags_we = 1'b0;
    chk("popwe_flags", 8'(flags_q), 8'h06);
    chk("popwe_count", 8'(count), 8'h0);

    // Asynchronous reset in the middle of activity
    load_flags(4'b1111);
    do_pop_op();
    chk("pre_rst_err", 8'(stack_err), 8'h1);
    repeat (3) do_push_op();
    chk("pre_rst_count", 8'(count), 8'h3);
    chk("pre_rst_flags", 8'(flags_q), 8'h0F);
    push = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_flags", 8'(flags_q), 8'h0);
    chk("async_count", 8'(count), 8'h0);
    chk("async_err", 8'(stack_err), 8'h0);
    push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", 8'(stack_empty), 8'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
